fitness_eval: RTL and testbench
===============================

FITNESS_EVAL -- requirements
Module: fitness_eval

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, gives the cycles each input vector is held before the circuit output is sampled; the legal range is 1..15.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: requests one evaluation run.
REQ-005 Port target, input, 16 bits: expected truth table; bit i is the expected circuit output for input vector i.
REQ-006 Port circ_inp, output, 4 bits: drives the 4-input evolvable grid's primary inputs.
REQ-007 Port circ_out, input, 1 bit: the grid's selected output.
REQ-008 Port busy, output, 1 bit: high while a run is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse marking the end of a run.
REQ-010 Port fitness, output, 5 bits: number of matching vectors, range 0..16.

Function
REQ-011 The FSM SHALL have states IDLE, APPLY and DONE.
REQ-012 IDLE: when start=1, the FSM SHALL latch target, clear fitness to 0, set circ_inp=0 and the settle count=0, then enter APPLY.
REQ-013 APPLY SHALL hold circ_inp for exactly SETTLE_CYCLES cycles, because the grid has combinational feedback that needs time to settle.
REQ-014 On the last hold cycle, circ_out SHALL be compared with latched target[circ_inp], and fitness SHALL increment by 1 on a match.
REQ-015 After sampling vector v<15, circ_inp SHALL become v+1 and the settle count SHALL reload.
REQ-016 After sampling vector 15, the FSM SHALL enter DONE; circ_inp is a 4-bit counter and SHALL NOT wrap into a second pass.
REQ-017 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-018 busy SHALL be 1 exactly while in APPLY.
REQ-019 Latency from the start-accept edge to the done-high cycle SHALL be 16*SETTLE_CYCLES+1 cycles.
REQ-020 fitness SHALL be final and stable from the done cycle until the next accepted start.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 start=1 during DONE SHALL be accepted as a new run, entering APPLY on the next edge with fitness cleared; done SHALL still pulse for that one cycle.
REQ-023 target changes during a run SHALL NOT affect the result; only the value latched at start is used.
REQ-024 fitness SHALL NOT overflow: it is 5 bits wide and at most 16 increments occur per run.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, circ_inp=0, settle count=0, fitness=0, busy=0, done=0 and the target latch=0.
REQ-026 Reset during APPLY SHALL abort the run without asserting done; a fresh start is required afterwards.

Configuration
REQ-027 With macro FITNESS_MISMATCH_MASK_EN defined, the block SHALL add output mismatch_mask, 16 bits.
REQ-028 mismatch_mask bit v SHALL be set when vector v mismatched, SHALL be cleared on start accept, and SHALL be held like fitness.
REQ-029 With FITNESS_MISMATCH_MASK_EN defined, fitness SHALL always equal 16 minus popcount(mismatch_mask) at done.
REQ-030 Without FITNESS_MISMATCH_MASK_EN, the port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package fitness_pkg SHALL hold NUM_INPUTS=4, NUM_VECTORS=16, FIT_W=5 and the state enum type.
REQ-032 Sub-module settle_timer SHALL provide the loadable down-counter that asserts a last-cycle flag; the FSM, vector counter and accumulator SHALL stay in fitness_eval.

Verification
REQ-033 Bench models the grid as 4-input AND, target=16'h8000, SETTLE_CYCLES=4, start pulse -> done after 65 cycles, fitness=16, mask=16'h0000.
REQ-034 Same AND model, target=16'h7FFF -> fitness=0, mask=16'hFFFF.
REQ-035 Model output 0 while the settle count is nonzero, target=16'hAAAA, SETTLE_CYCLES=1 -> fitness=8, mask=16'hAAAA, proving the sample timing.
REQ-036 Start re-pulsed at cycles 10 and 30 of a run -> exactly one done, latency unchanged; start held high through DONE -> back-to-back runs, fitness restarting at 0.
REQ-037 rst_n pulled low at circ_inp=7 -> all outputs 0 immediately, no done; subsequent run gives the correct result.
REQ-038 target changed mid-run from 16'h8000 to 16'h0000 -> fitness=16, matching the latched target.

Source files
------------

// File: rtl/fitness_pkg.sv
// Shared constants and FSM state type for the evolvable-grid fitness evaluator.
package fitness_pkg;

   localparam int NUM_INPUTS  = 4;
   localparam int NUM_VECTORS = 16;
   localparam int FIT_W       = 5;
   localparam int SETTLE_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags the last cycle of a SETTLE_CYCLES-long hold window.
module settle_timer
   import fitness_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic last
);

   // Loading SETTLE_CYCLES-1 makes the zero count land on the final hold cycle.
   localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   logic [SETTLE_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign last = (count == '0);

endmodule

// File: rtl/fitness_eval.sv
// Sweeps all 16 input vectors through the grid and counts matches against a latched truth table.
// Optional output mismatch_mask is enabled by defining FITNESS_MISMATCH_MASK_EN.
module fitness_eval
   import fitness_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [NUM_VECTORS-1:0] target,
   output logic [NUM_INPUTS-1:0]  circ_inp,
   input  logic                   circ_out,
   output logic                   busy,
   output logic                   done,
   output logic [FIT_W-1:0]       fitness
`ifdef FITNESS_MISMATCH_MASK_EN
   ,
   output logic [NUM_VECTORS-1:0] mismatch_mask
`endif
);

   state_t                 state;
   state_t                 state_nxt;
   logic [NUM_VECTORS-1:0] target_q;
   logic                   accept;
   logic                   last_hold;
   logic                   sample;
   logic                   final_vec;
   logic                   match;
   logic                   timer_load;

   // A new run may start from IDLE or directly out of DONE.
   assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign sample     = (state == ST_APPLY) && last_hold;
   assign final_vec  = (circ_inp == NUM_INPUTS'(NUM_VECTORS - 1));
   assign match      = (circ_out == target_q[circ_inp]);
   assign timer_load = accept || (sample && !final_vec);

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (timer_load),
      .en   (busy),
      .last (last_hold)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_APPLY;
         ST_APPLY: if (sample && final_vec) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = start ? ST_APPLY : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ST_APPLY: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default:  ;
      endcase
   end

   // Vector counter stops at 15 so a run never wraps into a second pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q <= '0;
         fitness  <= '0;
         circ_inp <= '0;
      end else if (accept) begin
         target_q <= target;
         fitness  <= '0;
         circ_inp <= '0;
      end else if (sample) begin
         fitness <= fitness + FIT_W'(match);
         if (!final_vec) begin
            circ_inp <= circ_inp + 1'b1;
         end
      end
   end

`ifdef FITNESS_MISMATCH_MASK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch_mask <= '0;
      end else if (accept) begin
         mismatch_mask <= '0;
      end else if (sample) begin
         mismatch_mask[circ_inp] <= !match;
      end
   end
`endif

endmodule

// File: tb/tb_fitness_eval.sv
// Bench for fitness_eval: two instances (SETTLE_CYCLES 4 and 1) driven by behavioural grid models.
// Mask checks are compiled in when FITNESS_MISMATCH_MASK_EN is defined.
module tb_fitness_eval;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [1:0]           start_v;
   logic [1:0]           busy_v;
   logic [1:0]           done_v;
   logic [1:0]           out_v;
   logic [1:0][15:0]     target_v;
   logic [1:0][15:0]     tt_v;
   logic [1:0][1:0]      mode_v;
   logic [1:0][3:0]      inp_v;
   logic [1:0][4:0]      fit_v;
   logic [1:0][15:0]     mask_v;
   int                   cyc = 0;
   int                   checks = 0;
   int                   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fitness_eval #(.SETTLE_CYCLES(4)) dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_v[0]),
      .target  (target_v[0]),
      .circ_inp(inp_v[0]),
      .circ_out(out_v[0]),
      .busy    (busy_v[0]),
      .done    (done_v[0]),
      .fitness (fit_v[0])
`ifdef FITNESS_MISMATCH_MASK_EN
      ,
      .mismatch_mask(mask_v[0])
`endif
   );

   fitness_eval #(.SETTLE_CYCLES(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_v[1]),
      .target  (target_v[1]),
      .circ_inp(inp_v[1]),
      .circ_out(out_v[1]),
      .busy    (busy_v[1]),
      .done    (done_v[1]),
      .fitness (fit_v[1])
`ifdef FITNESS_MISMATCH_MASK_EN
      ,
      .mismatch_mask(mask_v[1])
`endif
   );

`ifndef FITNESS_MISMATCH_MASK_EN
   assign mask_v = '0;
`endif

   // Grid models: mode 0 = 4-input AND, mode 1 = truth table tt but 0 until settled,
   // mode 2 = truth table tt but inverted until settled.
   for (genvar g = 0; g < 2; g++) begin : grid
      localparam int SG = (g == 0) ? 4 : 1;
      logic [3:0] prev_inp;
      logic       was_busy;
      int         hprev;
      int         hold;
      logic       settled;
      logic       o;

      always_comb begin
         hold = 0;
         if (busy_v[g] && was_busy && (inp_v[g] == prev_inp)) hold = hprev + 1;
      end

      always @(posedge clk) begin
         prev_inp <= inp_v[g];
         was_busy <= busy_v[g];
         hprev    <= hold;
      end

      always_comb begin
         settled = (mode_v[g] == 2'd0) ? (&inp_v[g]) : tt_v[g][inp_v[g]];
         o = settled;
         if ((mode_v[g] != 2'd0) && (hold != SG - 1)) o = (mode_v[g] == 2'd1) ? 1'b0 : ~settled;
      end

      assign out_v[g] = o;
   end

   function automatic int s_of(input int sel);
      return (sel == 0) ? 4 : 1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start_run(input int sel, input logic [15:0] tgt, input logic [1:0] mode,
                            input logic [15:0] tt, output int c0);
      @(negedge clk);
      mode_v[sel]   = mode;
      tt_v[sel]     = tt;
      target_v[sel] = tgt;
      start_v[sel]  = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      start_v[sel] = 1'b0;
      check_eq($sformatf("accept_busy%0d", sel), 32'(busy_v[sel]), 32'd1);
      check_eq($sformatf("accept_fit%0d", sel), 32'(fit_v[sel]), 32'd0);
   endtask

   // Waits for done and checks the result against the settled truth table and latched target.
   task automatic finish_run(input int sel, input int c0, input logic [15:0] tgt,
                             input logic [15:0] settled, input bit mid_pulse,
                             input bit chg_tgt, input logic [15:0] new_tgt,
                             input bit chain, output int c0_next);
      int          budget;
      bit          seen;
      int          gaps;
      int          n;
      logic [15:0] exp_mask;
      int          exp_fit;
      budget   = 16 * s_of(sel) + 10;
      seen     = 0;
      gaps     = 0;
      exp_mask = settled ^ tgt;
      exp_fit  = 16 - $countones(exp_mask);
      c0_next  = c0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(posedge clk);
         #1;
         n = cyc - c0;
         if (done_v[sel]) begin
            seen = 1;
         end else begin
            if (!busy_v[sel]) gaps++;
            start_v[sel] = mid_pulse && ((n == 10) || (n == 30));
            if (chg_tgt && (n == 20)) target_v[sel] = new_tgt;
         end
      end
      check_eq($sformatf("done_seen%0d", sel), 32'(seen), 32'd1);
      if (!seen) return;
      check_eq($sformatf("latency%0d", sel), 32'(cyc - c0 + 1), 32'(16 * s_of(sel) + 1));
      check_eq($sformatf("busy_gaps%0d", sel), 32'(gaps), 32'd0);
      check_eq($sformatf("busy_at_done%0d", sel), 32'(busy_v[sel]), 32'd0);
      check_eq($sformatf("fitness%0d", sel), 32'(fit_v[sel]), 32'(exp_fit));
      check_eq($sformatf("inp_end%0d", sel), 32'(inp_v[sel]), 32'd15);
`ifdef FITNESS_MISMATCH_MASK_EN
      check_eq($sformatf("mask%0d", sel), 32'(mask_v[sel]), 32'(exp_mask));
      check_eq($sformatf("mask_pop%0d", sel), 32'(fit_v[sel]), 32'(16 - $countones(mask_v[sel])));
`endif
      if (chain) begin
         start_v[sel] = 1'b1;
         @(posedge clk);
         #1;
         c0_next = cyc;
         start_v[sel] = 1'b0;
         check_eq($sformatf("chain_busy%0d", sel), 32'(busy_v[sel]), 32'd1);
         check_eq($sformatf("chain_fit%0d", sel), 32'(fit_v[sel]), 32'd0);
         check_eq($sformatf("chain_inp%0d", sel), 32'(inp_v[sel]), 32'd0);
`ifdef FITNESS_MISMATCH_MASK_EN
         check_eq($sformatf("chain_mask%0d", sel), 32'(mask_v[sel]), 32'd0);
`endif
      end else begin
         start_v[sel] = 1'b0;
         @(posedge clk);
         #1;
         check_eq($sformatf("done_pulse%0d", sel), 32'(done_v[sel]), 32'd0);
         check_eq($sformatf("idle_busy%0d", sel), 32'(busy_v[sel]), 32'd0);
         repeat (3) @(posedge clk);
         #1;
         check_eq($sformatf("fit_hold%0d", sel), 32'(fit_v[sel]), 32'(exp_fit));
      end
   endtask

   task automatic check_zero(input string tag, input int sel);
      check_eq({tag, "_busy"}, 32'(busy_v[sel]), 32'd0);
      check_eq({tag, "_done"}, 32'(done_v[sel]), 32'd0);
      check_eq({tag, "_fit"}, 32'(fit_v[sel]), 32'd0);
      check_eq({tag, "_inp"}, 32'(inp_v[sel]), 32'd0);
`ifdef FITNESS_MISMATCH_MASK_EN
      check_eq({tag, "_mask"}, 32'(mask_v[sel]), 32'd0);
`endif
   endtask

   initial begin
      int          c0;
      int          c1;
      int          dn;
      bit          reached;
      logic [15:0] tgt;
      logic [15:0] tt;
      rst_n    = 1'b0;
      start_v  = '0;
      target_v = '0;
      tt_v     = '0;
      mode_v   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("rst4", 0);
      check_zero("rst1", 1);
      @(negedge clk);
      rst_n = 1'b1;

      // AND grid against its own truth table, then against the complement.
      start_run(0, 16'h8000, 2'd0, 16'h0000, c0);
      finish_run(0, c0, 16'h8000, 16'h8000, 0, 0, 16'h0, 0, c1);
      start_run(0, 16'h7FFF, 2'd0, 16'h0000, c0);
      finish_run(0, c0, 16'h7FFF, 16'h8000, 0, 0, 16'h0, 0, c1);

      // Sample-timing cases: output only valid on the final hold cycle.
      start_run(1, 16'hAAAA, 2'd1, 16'h0000, c0);
      finish_run(1, c0, 16'hAAAA, 16'h0000, 0, 0, 16'h0, 0, c1);
      start_run(0, 16'hAAAA, 2'd1, 16'hFFFF, c0);
      finish_run(0, c0, 16'hAAAA, 16'hFFFF, 0, 0, 16'h0, 0, c1);

      // Start re-pulsed mid-run must be ignored.
      start_run(0, 16'h8000, 2'd0, 16'h0000, c0);
      finish_run(0, c0, 16'h8000, 16'h8000, 1, 0, 16'h0, 0, c1);

      // Start held through DONE gives back-to-back runs.
      start_run(0, 16'h8001, 2'd0, 16'h0000, c0);
      finish_run(0, c0, 16'h8001, 16'h8000, 0, 0, 16'h0, 1, c1);
      finish_run(0, c1, 16'h8001, 16'h8000, 0, 0, 16'h0, 0, c0);

      // Target changed mid-run: latched value wins.
      start_run(0, 16'h8000, 2'd0, 16'h0000, c0);
      finish_run(0, c0, 16'h8000, 16'h8000, 0, 1, 16'h0000, 0, c1);

      // Asynchronous reset while vector 7 is applied.
      start_run(0, 16'h8000, 2'd0, 16'h0000, c0);
      reached = 0;
      for (int k = 0; k < 100 && !reached; k++) begin
         @(posedge clk);
         #1;
         if (inp_v[0] == 4'd7) reached = 1;
      end
      check_eq("reach_vec7", 32'(reached), 32'd1);
      @(posedge clk);
      #1;
      check_eq("fit_before_rst", 32'(fit_v[0]), 32'd7);
      rst_n = 1'b0;
      #1;
      check_zero("async_rst", 0);
      dn = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         dn += int'(done_v[0]);
      end
      check_eq("no_done_in_rst", 32'(dn), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         dn += int'(done_v[0]) + int'(busy_v[0]);
      end
      check_eq("idle_after_rst", 32'(dn), 32'd0);
      start_run(0, 16'h8000, 2'd0, 16'h0000, c0);
      finish_run(0, c0, 16'h8000, 16'h8000, 0, 0, 16'h0, 0, c1);

      // Randomized runs on both instances with an adversarial settling model.
      for (int i = 0; i < 10; i++) begin
         int sel;
         bit mid;
         bit chg;
         sel = i % 2;
         tgt = 16'($urandom);
         tt  = 16'($urandom);
         mid = 1'($urandom);
         chg = 1'($urandom);
         start_run(sel, tgt, (sel == 0) ? 2'd2 : 2'd1, tt, c0);
         finish_run(sel, c0, tgt, tt, mid, chg, 16'($urandom), (i == 9), c1);
         if (i == 9) finish_run(sel, c1, tgt, tt, 0, 0, 16'h0, 0, c0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
